mc_ctrl: RTL and testbench

MC_CTRL -- requirements
Module: mc_ctrl

---
 rtl/mc_ctrl.sv | 170 +++++++++++++++++
 tb/tb_mc_ctrl.sv | 142 ++++++++++++++
 2 files changed

// File: rtl/mc_ctrl.sv
// Multi-cycle CPU control FSM: decodes the latched instruction class and sequences FETCH/DECODE/EXEC/MEM/WB.
// Latency: 2-5 cycles per instruction plus MEM wait cycles; strobes are combinational from state, class and inputs.
// Backpressure: MEM stalls on dm_ack=0 and aborts with mem_err after 16 unacknowledged cycles.
module mc_ctrl (
    input  logic        clk,
    input  logic        reset,
    input  logic [31:0] IR,
    input  logic        cmp_eq,
    input  logic        dm_ack,
    output logic [2:0]  state,
    output logic        IR_WE,
    output logic        PC_WE,
    output logic [1:0]  NPCsel,
    output logic        DM_RE,
    output logic        DM_WE,
    output logic        GRF_WE,
    output logic        instr_done,
    output logic        illegal,
    output logic        mem_err
);

    typedef enum logic [2:0] {
        S_FETCH  = 3'd0,
        S_DECODE = 3'd1,
        S_EXEC   = 3'd2,
        S_MEM    = 3'd3,
        S_WB     = 3'd4
    } st_t;

    typedef enum logic [3:0] {
        C_ILL, C_RALU, C_JR, C_JALR, C_IALU, C_LOAD, C_SW, C_SB, C_BEQ, C_J, C_JAL
    } cls_t;

    st_t        cur_st, next_st;
    cls_t       cls, ir_cls;
    logic [3:0] wait_cnt;
    logic [5:0] op, funct;
    logic       unused_ir;

    assign op        = IR[31:26];
    assign funct     = IR[5:0];
    assign unused_ir = ^IR[25:6];
    assign state     = cur_st;

    always_comb begin
        ir_cls = C_ILL;
        case (op)
            6'b000000: begin
                case (funct)
                    6'b100001, 6'b100011, 6'b101010,
                    6'b000000, 6'b100100: ir_cls = C_RALU;
                    6'b001000:            ir_cls = C_JR;
                    6'b001001:            ir_cls = C_JALR;
                    default:              ir_cls = C_ILL;
                endcase
            end
            6'b001101, 6'b001111, 6'b001001: ir_cls = C_IALU;
            6'b100011, 6'b100000, 6'b100100: ir_cls = C_LOAD;
            6'b101011:                       ir_cls = C_SW;
            6'b101000:                       ir_cls = C_SB;
            6'b000100:                       ir_cls = C_BEQ;
            6'b000010:                       ir_cls = C_J;
            6'b000011:                       ir_cls = C_JAL;
            default:                         ir_cls = C_ILL;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            cur_st   <= S_FETCH;
            cls      <= C_ILL;
            wait_cnt <= 4'd0;
        end else begin
            cur_st <= next_st;
            if (IR_WE)
                cls <= ir_cls;
            if (cur_st == S_EXEC)
                wait_cnt <= 4'd0;
            else if (cur_st == S_MEM && !dm_ack && wait_cnt != 4'd15)
                wait_cnt <= wait_cnt + 4'd1;
        end
    end

    always_comb begin
        next_st    = S_FETCH;
        IR_WE      = 1'b0;
        PC_WE      = 1'b0;
        NPCsel     = 2'd0;
        DM_RE      = 1'b0;
        DM_WE      = 1'b0;
        GRF_WE     = 1'b0;
        instr_done = 1'b0;
        illegal    = 1'b0;
        mem_err    = 1'b0;
        case (cur_st)
            S_FETCH: begin
                IR_WE   = 1'b1;
                PC_WE   = 1'b1;
                next_st = S_DECODE;
            end
            S_DECODE: begin
                next_st = S_EXEC;
                case (cls)
                    C_J:   begin PC_WE = 1'b1; NPCsel = 2'd1; instr_done = 1'b1; next_st = S_FETCH; end
                    C_JR:  begin PC_WE = 1'b1; NPCsel = 2'd2; instr_done = 1'b1; next_st = S_FETCH; end
                    C_ILL: begin illegal = 1'b1; instr_done = 1'b1; next_st = S_FETCH; end
                    default: ;
                endcase
            end
            S_EXEC: begin
                case (cls)
                    C_BEQ: begin
                        PC_WE      = cmp_eq;
                        NPCsel     = cmp_eq ? 2'd1 : 2'd0;
                        instr_done = 1'b1;
                        next_st    = S_FETCH;
                    end
                    C_LOAD, C_SW, C_SB: next_st = S_MEM;
                    default:            next_st = S_WB;
                endcase
            end
            S_MEM: begin
                // Ack wins over the timeout when both land on the last wait count.
                if (dm_ack || wait_cnt != 4'd15) begin
                    DM_RE = (cls == C_LOAD) || (cls == C_SB);
                    DM_WE = (cls == C_SW) || (cls == C_SB);
                end
                if (dm_ack) begin
                    if (cls == C_LOAD) begin
                        next_st = S_WB;
                    end else begin
                        instr_done = 1'b1;
                        next_st    = S_FETCH;
                    end
                end else if (wait_cnt == 4'd15) begin
                    mem_err    = 1'b1;
                    instr_done = 1'b1;
                    next_st    = S_FETCH;
                end else begin
                    next_st = S_MEM;
                end
            end
            S_WB: begin
                GRF_WE     = 1'b1;
                instr_done = 1'b1;
                if (cls == C_JAL) begin
                    PC_WE  = 1'b1;
                    NPCsel = 2'd1;
                end else if (cls == C_JALR) begin
                    PC_WE  = 1'b1;
                    NPCsel = 2'd2;
                end
            end
            default: next_st = S_FETCH;
        endcase
        // Reset masks every strobe in the same cycle so no partial memory or register write escapes.
        if (reset) begin
            IR_WE      = 1'b0;
            PC_WE      = 1'b0;
            NPCsel     = 2'd0;
            DM_RE      = 1'b0;
            DM_WE      = 1'b0;
            GRF_WE     = 1'b0;
            instr_done = 1'b0;
            illegal    = 1'b0;
            mem_err    = 1'b0;
        end
    end

endmodule

// File: tb/tb_mc_ctrl.sv
// Directed bench for mc_ctrl: drives inputs on the falling edge and checks the packed output vector 1 ns later.
module tb_mc_ctrl;

    logic        clk = 1'b0;
    logic        reset;
    logic [31:0] IR;
    logic        cmp_eq;
    logic        dm_ack;
    logic [2:0]  state;
    logic        IR_WE, PC_WE, DM_RE, DM_WE, GRF_WE, instr_done, illegal, mem_err;
    logic [1:0]  NPCsel;
    logic [12:0] got;

    int vec_cnt = 0;
    int err_cnt = 0;

    localparam logic [31:0] I_ADDU = 32'h0000_0021;
    localparam logic [31:0] I_LW   = 32'h8C00_0000;
    localparam logic [31:0] I_SW   = 32'hAC00_0000;
    localparam logic [31:0] I_SB   = 32'hA000_0000;
    localparam logic [31:0] I_BEQ  = 32'h1000_0000;
    localparam logic [31:0] I_JAL  = 32'h0C00_0000;
    localparam logic [31:0] I_J    = 32'h0800_0000;
    localparam logic [31:0] I_JR   = 32'h0000_0008;
    localparam logic [31:0] I_ILL  = 32'hFC00_0000;

    always #5 clk = ~clk;

    mc_ctrl dut (
        .clk        (clk),
        .reset      (reset),
        .IR         (IR),
        .cmp_eq     (cmp_eq),
        .dm_ack     (dm_ack),
        .state      (state),
        .IR_WE      (IR_WE),
        .PC_WE      (PC_WE),
        .NPCsel     (NPCsel),
        .DM_RE      (DM_RE),
        .DM_WE      (DM_WE),
        .GRF_WE     (GRF_WE),
        .instr_done (instr_done),
        .illegal    (illegal),
        .mem_err    (mem_err)
    );

    assign got = {state, IR_WE, PC_WE, NPCsel, DM_RE, DM_WE, GRF_WE, instr_done, illegal, mem_err};

    // Expected vector: state, IR_WE, PC_WE, NPCsel, DM_RE, DM_WE, GRF_WE, instr_done, illegal, mem_err
    function automatic logic [12:0] e(input int st, input int irwe, input int pcwe, input int npc,
                                      input int dmre, input int dmwe, input int grf, input int done,
                                      input int ill, input int merr);
        return {st[2:0], irwe[0], pcwe[0], npc[1:0], dmre[0], dmwe[0], grf[0], done[0], ill[0], merr[0]};
    endfunction

    task automatic drv(input logic [31:0] ir, input logic c, input logic a, input logic r);
        @(negedge clk);
        IR     = ir;
        cmp_eq = c;
        dm_ack = a;
        reset  = r;
        #1;
    endtask

    task automatic chk(input string tag, input logic [12:0] expv);
        vec_cnt++;
        assert (got === expv) else begin
            err_cnt++;
            $error("FAIL %s: observed %b expected %b", tag, got, expv);
        end
    endtask

    initial begin
        reset = 1'b1; IR = 32'h0; cmp_eq = 1'b0; dm_ack = 1'b0;

        drv(I_ADDU, 1'b0, 1'b0, 1'b1); chk("reset0", e(0,0,0,0,0,0,0,0,0,0));
        drv(I_ADDU, 1'b1, 1'b1, 1'b1); chk("reset1", e(0,0,0,0,0,0,0,0,0,0));

        drv(I_ADDU, 1'b0, 1'b0, 1'b0); chk("addu_fetch", e(0,1,1,0,0,0,0,0,0,0));
        drv(I_ADDU, 1'b0, 1'b0, 1'b0); chk("addu_dec",   e(1,0,0,0,0,0,0,0,0,0));
        drv(I_ADDU, 1'b0, 1'b0, 1'b0); chk("addu_exec",  e(2,0,0,0,0,0,0,0,0,0));
        drv(I_ADDU, 1'b0, 1'b0, 1'b0); chk("addu_wb",    e(4,0,0,0,0,0,1,1,0,0));

        drv(I_LW, 1'b0, 1'b0, 1'b0); chk("lw_fetch", e(0,1,1,0,0,0,0,0,0,0));
        drv(I_LW, 1'b0, 1'b0, 1'b0); chk("lw_dec",   e(1,0,0,0,0,0,0,0,0,0));
        drv(I_LW, 1'b0, 1'b0, 1'b0); chk("lw_exec",  e(2,0,0,0,0,0,0,0,0,0));
        for (int i = 0; i < 3; i++) begin
            drv(I_LW, 1'b0, 1'b0, 1'b0); chk("lw_mem_wait", e(3,0,0,0,1,0,0,0,0,0));
        end
        drv(I_LW, 1'b0, 1'b1, 1'b0); chk("lw_mem_ack", e(3,0,0,0,1,0,0,0,0,0));
        drv(I_LW, 1'b0, 1'b0, 1'b0); chk("lw_wb",      e(4,0,0,0,0,0,1,1,0,0));

        drv(I_BEQ, 1'b1, 1'b0, 1'b0); chk("beq1_fetch", e(0,1,1,0,0,0,0,0,0,0));
        drv(I_BEQ, 1'b1, 1'b0, 1'b0); chk("beq1_dec",   e(1,0,0,0,0,0,0,0,0,0));
        drv(I_BEQ, 1'b1, 1'b0, 1'b0); chk("beq1_exec",  e(2,0,1,1,0,0,0,1,0,0));
        drv(I_BEQ, 1'b0, 1'b0, 1'b0); chk("beq0_fetch", e(0,1,1,0,0,0,0,0,0,0));
        drv(I_BEQ, 1'b0, 1'b0, 1'b0); chk("beq0_dec",   e(1,0,0,0,0,0,0,0,0,0));
        drv(I_BEQ, 1'b0, 1'b0, 1'b0); chk("beq0_exec",  e(2,0,0,0,0,0,0,1,0,0));

        drv(I_SB, 1'b0, 1'b0, 1'b0); chk("sb_fetch", e(0,1,1,0,0,0,0,0,0,0));
        drv(I_SB, 1'b0, 1'b0, 1'b0); chk("sb_dec",   e(1,0,0,0,0,0,0,0,0,0));
        drv(I_SB, 1'b0, 1'b0, 1'b0); chk("sb_exec",  e(2,0,0,0,0,0,0,0,0,0));
        for (int i = 0; i < 15; i++) begin
            drv(I_SB, 1'b0, 1'b0, 1'b0); chk("sb_mem_wait", e(3,0,0,0,1,1,0,0,0,0));
        end
        drv(I_SB, 1'b0, 1'b0, 1'b0); chk("sb_timeout", e(3,0,0,0,0,0,0,1,0,1));

        drv(I_JAL, 1'b0, 1'b0, 1'b0); chk("jal_fetch", e(0,1,1,0,0,0,0,0,0,0));
        drv(I_JAL, 1'b0, 1'b0, 1'b0); chk("jal_dec",   e(1,0,0,0,0,0,0,0,0,0));
        drv(I_JAL, 1'b0, 1'b0, 1'b0); chk("jal_exec",  e(2,0,0,0,0,0,0,0,0,0));
        drv(I_JAL, 1'b0, 1'b0, 1'b0); chk("jal_wb",    e(4,0,1,1,0,0,1,1,0,0));

        drv(I_LW, 1'b0, 1'b0, 1'b0); chk("lw15_fetch", e(0,1,1,0,0,0,0,0,0,0));
        drv(I_LW, 1'b0, 1'b0, 1'b0); chk("lw15_dec",   e(1,0,0,0,0,0,0,0,0,0));
        drv(I_LW, 1'b0, 1'b0, 1'b0); chk("lw15_exec",  e(2,0,0,0,0,0,0,0,0,0));
        for (int i = 0; i < 15; i++) begin
            drv(I_LW, 1'b0, 1'b0, 1'b0); chk("lw15_mem_wait", e(3,0,0,0,1,0,0,0,0,0));
        end
        drv(I_LW, 1'b0, 1'b1, 1'b0); chk("lw15_ack_prio", e(3,0,0,0,1,0,0,0,0,0));
        drv(I_LW, 1'b0, 1'b0, 1'b0); chk("lw15_wb",       e(4,0,0,0,0,0,1,1,0,0));

        drv(I_ILL, 1'b0, 1'b0, 1'b0); chk("ill_fetch", e(0,1,1,0,0,0,0,0,0,0));
        drv(I_ILL, 1'b0, 1'b0, 1'b0); chk("ill_dec",   e(1,0,0,0,0,0,0,1,1,0));

        drv(I_J, 1'b0, 1'b0, 1'b0); chk("j_fetch", e(0,1,1,0,0,0,0,0,0,0));
        drv(I_J, 1'b0, 1'b0, 1'b0); chk("j_dec",   e(1,0,1,1,0,0,0,1,0,0));

        drv(I_JR, 1'b0, 1'b0, 1'b0); chk("jr_fetch", e(0,1,1,0,0,0,0,0,0,0));
        drv(I_JR, 1'b0, 1'b0, 1'b0); chk("jr_dec",   e(1,0,1,2,0,0,0,1,0,0));

        drv(I_SW, 1'b0, 1'b0, 1'b0); chk("sw_fetch", e(0,1,1,0,0,0,0,0,0,0));
        drv(I_SW, 1'b0, 1'b0, 1'b0); chk("sw_dec",   e(1,0,0,0,0,0,0,0,0,0));
        drv(I_SW, 1'b0, 1'b0, 1'b0); chk("sw_exec",  e(2,0,0,0,0,0,0,0,0,0));
        drv(I_SW, 1'b0, 1'b0, 1'b0); chk("sw_mem1",  e(3,0,0,0,0,1,0,0,0,0));
        drv(I_SW, 1'b0, 1'b0, 1'b1); chk("sw_mem2_reset", e(3,0,0,0,0,0,0,0,0,0));
        drv(I_SW, 1'b0, 1'b0, 1'b0); chk("sw_post_reset", e(0,1,1,0,0,0,0,0,0,0));

        $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, err_cnt);
        $finish;
    end

endmodule
